// File: rtl/mul_pkg.sv
// Shared types and tile geometry for the digit-serial multiplier sequencer.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TILE_A_W = 2;
    localparam int TILE_B_W = 3;
    localparam int TILE_P_W = 5;

endpackage : mul_pkg

// File: rtl/mul_digit_counter.sv
// Digit-pair walker: j (B digit) is the inner index and i (A digit) the outer one.
// A skipped row advances i directly. o_last marks the final step of a product.
module mul_digit_counter #(
    parameter int NA = 4,
    parameter int NB = 3,
    parameter int IW = 2,
    parameter int JW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_step,
    input  logic          i_skip,
    output logic [IW-1:0] o_i,
    output logic [JW-1:0] o_j,
    output logic          o_last
);

    logic [IW-1:0] r_i;
    logic [JW-1:0] r_j;
    logic          w_row_end;

    // A row ends on its last B digit, or right away when the row is skipped.
    assign w_row_end = i_skip || (r_j == JW'(NB - 1));
    assign o_last    = (r_i == IW'(NA - 1)) && w_row_end;
    assign o_i       = r_i;
    assign o_j       = r_j;

    // Advance j every step; wrap it at the row end and move to the next row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_start) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_step) begin
            if (w_row_end) begin
                r_j <= '0;
                r_i <= (r_i == IW'(NA - 1)) ? '0 : r_i + IW'(1);
            end else begin
                r_j <= r_j + JW'(1);
            end
        end
    end

endmodule : mul_digit_counter

// File: rtl/mul_tile_sequencer.sv
// Computes A*B by feeding 2-bit A digits and 3-bit B digits to one external
// 2x3 tile multiplier, one digit pair per cycle, and accumulating the shifted
// tile products. Rows whose A digit is zero can be skipped in a single cycle.
module mul_tile_sequencer
    import mul_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int B_W       = 9,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [A_W-1:0]      in_a,
    input  logic [B_W-1:0]      in_b,
    output logic [TILE_A_W-1:0] tile_a,
    output logic [TILE_B_W-1:0] tile_b,
    input  logic [TILE_P_W-1:0] tile_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [A_W+B_W-1:0]  out_p,
    output logic                busy
);

    localparam int NA   = A_W / TILE_A_W;
    localparam int NB   = B_W / TILE_B_W;
    localparam int P_W  = A_W + B_W;
    localparam int IW   = (NA > 1) ? $clog2(NA) : 1;
    localparam int JW   = (NB > 1) ? $clog2(NB) : 1;
    // Largest shift is P_W-5, so $clog2(P_W) bits always hold it.
    localparam int SH_W = $clog2(P_W);

    // Operand widths must split evenly into tile digits.
    generate
        if ((A_W % TILE_A_W) != 0 || A_W < TILE_A_W) begin : g_bad_a_w
            $error("mul_tile_sequencer: A_W must be a positive multiple of 2");
        end
        if ((B_W % TILE_B_W) != 0 || B_W < TILE_B_W) begin : g_bad_b_w
            $error("mul_tile_sequencer: B_W must be a positive multiple of 3");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;
    logic [A_W-1:0]      r_a;
    logic [B_W-1:0]      r_b;
    logic [P_W-1:0]      r_acc;

    logic [IW-1:0]       w_i;
    logic [JW-1:0]       w_j;
    logic                w_last;
    logic                w_capture;
    logic                w_step;
    logic                w_acc_en;
    logic                w_skip;
    logic [TILE_A_W-1:0] w_a_cur;
    logic [TILE_B_W-1:0] w_b_cur;
    logic [SH_W-1:0]     w_shamt;
    logic [P_W-1:0]      w_term;

    logic [TILE_A_W-1:0] w_a_dig [NA];
    logic [TILE_B_W-1:0] w_b_dig [NB];

    // Slice the held operands into digit arrays for the muxes.
    genvar gi;
    generate
        for (gi = 0; gi < NA; gi++) begin : g_a_dig
            assign w_a_dig[gi] = r_a[gi*TILE_A_W +: TILE_A_W];
        end
        for (gi = 0; gi < NB; gi++) begin : g_b_dig
            assign w_b_dig[gi] = r_b[gi*TILE_B_W +: TILE_B_W];
        end
    endgenerate

    assign w_a_cur = w_a_dig[w_i];
    assign w_b_cur = w_b_dig[w_j];
    // Skip decision is only taken at the start of a row (j == 0).
    assign w_skip  = SKIP_ZERO && (w_a_cur == '0) && (w_j == '0);
    assign w_shamt = SH_W'(TILE_A_W * w_i) + SH_W'(TILE_B_W * w_j);
    assign w_term  = P_W'(tile_p) << w_shamt;
    assign out_p   = r_acc;

    mul_digit_counter #(
        .NA (NA),
        .NB (NB),
        .IW (IW),
        .JW (JW)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_capture),
        .i_step  (w_step),
        .i_skip  (w_skip),
        .o_i     (w_i),
        .o_j     (w_j),
        .o_last  (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/tile outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        tile_a       = '0;
        tile_b       = '0;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_acc_en     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (!w_skip) begin
                    tile_a   = w_a_cur;
                    tile_b   = w_b_cur;
                    w_acc_en = 1'b1;
                end
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                busy         = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture and accumulation of shifted tile products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (w_capture) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= '0;
        end else if (w_acc_en) begin
            r_acc <= r_acc + w_term;
        end
    end

endmodule : mul_tile_sequencer
